mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/arb_grant_logic.sv | 26 ++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for mem_port_arbiter: FSM states, port owner and counter widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_e;

  localparam int MEM_LATENCY_DEFAULT    = 1;
  localparam int MAX_DATA_BURST_DEFAULT = 4;
  localparam int CNT_W                  = 4;
  localparam logic [3:0] BYTE_ALL       = 4'b1111;

  // Counter preload so that mem_ce stays high for exactly `lat` cycles.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_grant_logic.sv
// Combinational winner selection for mem_port_arbiter: DM priority with an IF anti-starvation burst limit.
module arb_grant_logic
  import mem_port_arbiter_pkg::*;
#(
  parameter int MaxDataBurst = MAX_DATA_BURST_DEFAULT
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_if,
  output logic             grant_dm,
  output logic [CNT_W-1:0] streak_nxt
);

  localparam logic [CNT_W-1:0] BurstLim = CNT_W'(MaxDataBurst);

  always_comb begin
    grant_if   = if_req && (!dm_req || (streak == BurstLim));
    grant_dm   = dm_req && !grant_if;
    streak_nxt = streak;
    // Streak only counts DM grants that actually made IF wait.
    if (grant_if)      streak_nxt = '0;
    else if (grant_dm) streak_nxt = if_req ? (streak + CNT_W'(1)) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between CPU IF (read-only) and DM (read/write) ports, fixed-latency window.
// Optional performance counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 32,
  parameter int MemLatency   = MEM_LATENCY_DEFAULT,
  parameter int MaxDataBurst = MAX_DATA_BURST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_ack,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [AddrWidth-1:0] dm_addr,
  input  logic [3:0]           dm_byte_slct,
  input  logic [DataWidth-1:0] dm_wdata,
  output logic                 dm_ack,
  output logic [DataWidth-1:0] dm_rdata,
  output logic                 mem_ce,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [3:0]           mem_byte_slct,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_conflicts,
  output logic [31:0]          perf_if_wait
`endif
);

  localparam logic [CNT_W-1:0] LatLoad = lat_load(MemLatency);

  arb_state_e             state_q, state_d;
  arb_owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       streak_q, streak_d;
  logic                   mem_ce_d, mem_we_d;
  logic [AddrWidth-1:0]   mem_addr_d;
  logic [3:0]             mem_byte_slct_d;
  logic [DataWidth-1:0]   mem_wdata_d;
  logic                   if_ack_d, dm_ack_d;
  logic [DataWidth-1:0]   if_rdata_d, dm_rdata_d;

  logic                   grant_if, grant_dm;
  logic [CNT_W-1:0]       streak_nxt;

  arb_grant_logic #(
    .MaxDataBurst(MaxDataBurst)
  ) u_grant (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .streak    (streak_q),
    .grant_if  (grant_if),
    .grant_dm  (grant_dm),
    .streak_nxt(streak_nxt)
  );

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    streak_d        = streak_q;
    mem_ce_d        = mem_ce;
    mem_we_d        = mem_we;
    mem_addr_d      = mem_addr;
    mem_byte_slct_d = mem_byte_slct;
    mem_wdata_d     = mem_wdata;
    if_ack_d        = 1'b0;
    dm_ack_d        = 1'b0;
    if_rdata_d      = if_rdata;
    dm_rdata_d      = dm_rdata;
    case (state_q)
      ARB_IDLE: begin
        if (grant_if || grant_dm) begin
          state_d         = ARB_ACCESS;
          owner_d         = grant_dm ? OWNER_DM : OWNER_IF;
          cnt_d           = LatLoad;
          streak_d        = streak_nxt;
          mem_ce_d        = 1'b1;
          mem_we_d        = grant_dm && dm_we;
          mem_addr_d      = grant_dm ? dm_addr : if_addr;
          mem_byte_slct_d = grant_dm ? dm_byte_slct : BYTE_ALL;
          mem_wdata_d     = grant_dm ? dm_wdata : '0;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = ARB_RESP;
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
          // Ack is registered here so it lands in the RESP cycle.
          if (owner_q == OWNER_DM) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_we ? '0 : mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWNER_IF;
      cnt_q         <= '0;
      streak_q      <= '0;
      mem_ce        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_byte_slct <= '0;
      mem_wdata     <= '0;
      if_ack        <= 1'b0;
      dm_ack        <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      streak_q      <= streak_d;
      mem_ce        <= mem_ce_d;
      mem_we        <= mem_we_d;
      mem_addr      <= mem_addr_d;
      mem_byte_slct <= mem_byte_slct_d;
      mem_wdata     <= mem_wdata_d;
      if_ack        <= if_ack_d;
      dm_ack        <= dm_ack_d;
      if_rdata      <= if_rdata_d;
      dm_rdata      <= dm_rdata_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts <= '0;
      perf_if_wait   <= '0;
    end else begin
      if (state_q == ARB_IDLE && if_req && dm_req) perf_conflicts <= perf_conflicts + 32'd1;
      if (if_req && !if_ack)                       perf_if_wait   <= perf_if_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: latency-1 instance for arbitration, latency-3 instance for mid-access reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byte_slct, mem_byte_slct;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l3_rst, l3_if_req, l3_if_ack, l3_dm_req, l3_dm_we, l3_dm_ack;
  logic [31:0] l3_if_addr, l3_if_rdata, l3_dm_addr, l3_dm_wdata, l3_dm_rdata;
  logic [3:0]  l3_dm_byte_slct, l3_mem_byte_slct;
  logic        l3_mem_ce, l3_mem_we;
  logic [31:0] l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  logic [31:0] mem [0:63];
  logic        mem_inited = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [31:0] if_q[$], dm_q[$], l3_q[$];

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'h24020005;
    if (i == 16) return 32'h12345678;
    return 32'hA5000000 | 32'(i);
  endfunction

  mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .MemLatency(1), .MaxDataBurst(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_byte_slct(dm_byte_slct),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byte_slct(mem_byte_slct),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .MemLatency(3), .MaxDataBurst(4)) u_dut_l3 (
    .clk(clk), .rst(l3_rst),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ack(l3_if_ack), .if_rdata(l3_if_rdata),
    .dm_req(l3_dm_req), .dm_we(l3_dm_we), .dm_addr(l3_dm_addr), .dm_byte_slct(l3_dm_byte_slct),
    .dm_wdata(l3_dm_wdata), .dm_ack(l3_dm_ack), .dm_rdata(l3_dm_rdata),
    .mem_ce(l3_mem_ce), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_byte_slct(l3_mem_byte_slct),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata)
  );

  // Combinational-read memory with byte-lane writes; only the latency-1 instance writes.
  assign mem_rdata    = mem[mem_addr[7:2]];
  assign l3_mem_rdata = mem[l3_mem_addr[7:2]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (mem_ce && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_slct[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(negedge clk);
    total++;
    if (if_ack && dm_ack) begin
      bad++;
      $display("FAIL ack_overlap: if_ack=%b dm_ack=%b, required at most one high", if_ack, dm_ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_byte_slct = '0; dm_wdata = '0;
    l3_rst = 1'b1; l3_if_req = 1'b0; l3_if_addr = '0; l3_dm_req = 1'b0; l3_dm_we = 1'b0;
    l3_dm_addr = '0; l3_dm_byte_slct = '0; l3_dm_wdata = '0;
    tick(); tick();
    total++;
    if ({mem_ce, mem_we, mem_addr, mem_byte_slct, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ce=%b we=%b addr=%h bs=%b wd=%h ack=%b%b ird=%h drd=%h, required all 0",
               mem_ce, mem_we, mem_addr, mem_byte_slct, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata);
    end
    total++;
    if ({l3_mem_ce, l3_mem_we, l3_mem_addr, l3_mem_byte_slct, l3_mem_wdata, l3_if_ack, l3_dm_ack,
         l3_if_rdata, l3_dm_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_l3: ce=%b ack=%b%b addr=%h, required all 0",
               l3_mem_ce, l3_if_ack, l3_dm_ack, l3_mem_addr);
    end
    rst = 1'b0; l3_rst = 1'b0;
  endtask

  task automatic test_if_read();
    logic [31:0] exp;
    if_addr = 32'h10; if_req = 1'b1;
    if_q.push_back(init_word(4));
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (mem_ce !== (k == 1)) begin bad++; $display("FAIL if_read_ce: t+%0d got %b required %b", k, mem_ce, (k == 1)); end
      total++;
      if (if_ack !== (k == 2)) begin bad++; $display("FAIL if_read_ack: t+%0d got %b required %b", k, if_ack, (k == 2)); end
      total++;
      if (dm_ack !== 1'b0) begin bad++; $display("FAIL if_read_dm_ack: t+%0d got %b required 0", k, dm_ack); end
      if (k == 1) begin
        total++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
          bad++; $display("FAIL if_read_cmd: addr=%h we=%b required addr=00000010 we=0", mem_addr, mem_we);
        end
      end
      if (if_ack && if_q.size() > 0) begin
        exp = if_q.pop_front();
        total++;
        if (if_rdata !== exp) begin bad++; $display("FAIL if_read_data: got %h required %h", if_rdata, exp); end
        if_req = 1'b0;
      end
    end
    if_req = 1'b0; if_q.delete();
  endtask

  task automatic test_conflict();
    logic [31:0] exp;
    int if_grant_k;
    if_grant_k = -1;
    if_addr = 32'h10; if_req = 1'b1;
    dm_addr = 32'h40; dm_we = 1'b0; dm_byte_slct = 4'hF; dm_req = 1'b1;
    if_q.push_back(init_word(4));
    dm_q.push_back(init_word(16));
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (dm_ack !== (k == 2)) begin bad++; $display("FAIL conflict_dm_ack: t+%0d got %b required %b", k, dm_ack, (k == 2)); end
      total++;
      if (if_ack !== (k == 5)) begin bad++; $display("FAIL conflict_if_ack: t+%0d got %b required %b", k, if_ack, (k == 5)); end
      if (mem_ce && mem_addr == 32'h10 && if_grant_k < 0) if_grant_k = k;
      if (dm_ack && dm_q.size() > 0) begin
        exp = dm_q.pop_front();
        total++;
        if (dm_rdata !== exp) begin bad++; $display("FAIL conflict_dm_data: got %h required %h", dm_rdata, exp); end
        dm_req = 1'b0;
      end
      if (if_ack && if_q.size() > 0) begin
        exp = if_q.pop_front();
        total++;
        if (if_rdata !== exp) begin bad++; $display("FAIL conflict_if_data: got %h required %h", if_rdata, exp); end
        if_req = 1'b0;
      end
    end
    total++;
    if (if_grant_k != 4) begin
      bad++; $display("FAIL conflict_if_grant: IF granted at t+%0d required t+3", if_grant_k - 1);
    end
    if_req = 1'b0; dm_req = 1'b0; if_q.delete(); dm_q.delete();
  endtask

  task automatic test_dm_write();
    logic [31:0] exp;
    int we_cycles;
    bit got;
    we_cycles = 0;
    dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'hDEADBEEF; dm_byte_slct = 4'b0011; dm_req = 1'b1;
    dm_q.push_back(32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (mem_we) begin
        we_cycles++;
        total++;
        if ({mem_ce, mem_byte_slct, mem_wdata, mem_addr} !== {1'b1, 4'b0011, 32'hDEADBEEF, 32'h44}) begin
          bad++; $display("FAIL dm_write_cmd: ce=%b bs=%b wd=%h addr=%h required 1 0011 deadbeef 00000044",
                          mem_ce, mem_byte_slct, mem_wdata, mem_addr);
        end
      end
      total++;
      if (dm_ack !== (k == 2)) begin bad++; $display("FAIL dm_write_ack: t+%0d got %b required %b", k, dm_ack, (k == 2)); end
      if (dm_ack && dm_q.size() > 0) begin
        exp = dm_q.pop_front();
        total++;
        if (dm_rdata !== exp) begin bad++; $display("FAIL dm_write_rdata: got %h required %h", dm_rdata, exp); end
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
    total++;
    if (we_cycles != 1) begin bad++; $display("FAIL dm_write_we_len: got %0d cycles required 1", we_cycles); end
    // Read back: only the two low byte lanes take the write data.
    dm_req = 1'b0; dm_we = 1'b0; dm_q.delete();
    dm_addr = 32'h44; dm_byte_slct = 4'hF; dm_req = 1'b1;
    dm_q.push_back((init_word(17) & 32'hFFFF0000) | (32'hDEADBEEF & 32'h0000FFFF));
    got = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      tick();
      if (dm_ack) begin
        got = 1'b1;
        exp = dm_q.pop_front();
        total++;
        if (dm_rdata !== exp) begin bad++; $display("FAIL dm_readback: got %h required %h", dm_rdata, exp); end
        dm_req = 1'b0;
      end
    end
    total++;
    if (!got) begin bad++; $display("FAIL dm_readback_timeout: no dm_ack in 10 cycles, required one"); end
    dm_req = 1'b0; dm_q.delete();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0]  order_got;
    logic [31:0] exp;
    int n, last, k;
    order_got = '0; n = 0; last = -1; k = 0;
    if_addr = 32'h10; dm_addr = 32'h40; dm_we = 1'b0; dm_byte_slct = 4'hF;
    if_req = 1'b1; dm_req = 1'b1;
    if_q.push_back(init_word(4));
    dm_q.push_back(init_word(16));
    while (n < 10 && k < 60) begin
      tick(); k++;
      if (if_ack || dm_ack) begin
        order_got[n] = if_ack;
        if (last >= 0) begin
          total++;
          if (k - last != 3) begin bad++; $display("FAIL b2b_spacing: ack %0d after %0d cycles required 3", n, k - last); end
        end
        last = k;
        if (if_ack && if_q.size() > 0) begin
          exp = if_q.pop_front();
          total++;
          if (if_rdata !== exp) begin bad++; $display("FAIL b2b_if_data: got %h required %h", if_rdata, exp); end
          if (n < 9) if_q.push_back(init_word(4));
        end
        if (dm_ack && dm_q.size() > 0) begin
          exp = dm_q.pop_front();
          total++;
          if (dm_rdata !== exp) begin bad++; $display("FAIL b2b_dm_data: got %h required %h", dm_rdata, exp); end
          if (n < 9) dm_q.push_back(init_word(16));
        end
        n++;
        if (n == 10) begin if_req = 1'b0; dm_req = 1'b0; end
      end
    end
    total++;
    if (n != 10) begin bad++; $display("FAIL b2b_timeout: got %0d acks required 10", n); end
    total++;
    if (order_got !== 10'b1000010000) begin
      bad++; $display("FAIL b2b_order: got %b required 1000010000 (bit n=1 means IF)", order_got);
    end
    if_req = 1'b0; dm_req = 1'b0; if_q.delete(); dm_q.delete();
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] exp;
    l3_if_addr = 32'h10; l3_if_req = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++;
      if (l3_mem_ce !== 1'b1) begin bad++; $display("FAIL rst_mid_ce_pre: t+%0d got %b required 1", k, l3_mem_ce); end
    end
    l3_rst = 1'b1; l3_if_req = 1'b0;
    tick();
    total++;
    if (l3_mem_ce !== 1'b0 || l3_if_ack !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: ce=%b ack=%b required 0 0", l3_mem_ce, l3_if_ack);
    end
    l3_rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (l3_if_ack !== 1'b0 || l3_mem_ce !== 1'b0) begin
        bad++; $display("FAIL rst_mid_quiet: +%0d ack=%b ce=%b required 0 0", k, l3_if_ack, l3_mem_ce);
      end
    end
    l3_if_req = 1'b1;
    l3_q.push_back(init_word(4));
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (l3_mem_ce !== (k <= 3)) begin bad++; $display("FAIL rst_mid_reissue_ce: t+%0d got %b required %b", k, l3_mem_ce, (k <= 3)); end
      total++;
      if (l3_if_ack !== (k == 4)) begin bad++; $display("FAIL rst_mid_reissue_ack: t+%0d got %b required %b", k, l3_if_ack, (k == 4)); end
      if (l3_if_ack && l3_q.size() > 0) begin
        exp = l3_q.pop_front();
        total++;
        if (l3_if_rdata !== exp) begin bad++; $display("FAIL rst_mid_reissue_data: got %h required %h", l3_if_rdata, exp); end
        l3_if_req = 1'b0;
      end
    end
    l3_if_req = 1'b0; l3_q.delete();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_conflict();
    test_dm_write();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
